// File: rtl/cache_fill_fsm.sv
// Cache miss fill sequencer: fetches a whole block from pipelined memory,
// streams each returned word into the cache and writes the tag with the last word.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  output logic        mem_enable,
  output logic [15:0] mem_address,
  output logic        miss_fixing,
  output logic [15:0] memory_address,
  output logic [15:0] memory_data,
  output logic        memory_data_write,
  output logic        memory_tag_write,
  output logic        stall,
  output logic        fill_done
);

  localparam int OFF_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t            state, state_next;
  logic [15:0]       base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic              issued_all;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // issue_cnt holds at the last word once all requests are out, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base       <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issued_all <= 1'b0;
    end else if (state == IDLE && miss_detected) begin
      base       <= {miss_address[15:OFF_W], {OFF_W{1'b0}}};
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issued_all <= 1'b0;
    end else if (state == FILL) begin
      if (mem_enable) begin
        if (issue_cnt == LAST) issued_all <= 1'b1;
        else                   issue_cnt  <= issue_cnt + 1'b1;
      end
      if (memory_data_write) ret_cnt <= ret_cnt + 1'b1;
    end
  end

  assign mem_address    = base + 16'({issue_cnt, 1'b0});
  assign memory_address = base + 16'({ret_cnt, 1'b0});
  assign memory_data    = mem_data_in;

  always_comb begin
    state_next        = state;
    miss_fixing       = 1'b0;
    stall             = 1'b0;
    mem_enable        = 1'b0;
    fill_done         = 1'b0;
    memory_data_write = 1'b0;
    memory_tag_write  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst_n so every 1-bit output reads 0 while reset is held.
        stall = miss_detected & rst_n;
        if (miss_detected) state_next = FILL;
      end
      FILL: begin
        miss_fixing       = 1'b1;
        stall             = 1'b1;
        mem_enable        = ~issued_all;
        memory_data_write = mem_data_valid;
        memory_tag_write  = mem_data_valid && (ret_cnt == LAST);
        if (memory_tag_write) state_next = DONE;
      end
      DONE: begin
        fill_done  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a transaction-level fill model checked every
// cycle, a latency-programmable in-order memory, and literal pins on key fills.
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_enable;
  logic [15:0] mem_address;
  logic        miss_fixing;
  logic [15:0] memory_address;
  logic [15:0] memory_data;
  logic        memory_data_write;
  logic        memory_tag_write;
  logic        stall;
  logic        fill_done;

  cache_fill_fsm #(.WORDS_PER_BLOCK(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_data_in(mem_data_in), .mem_data_valid(mem_data_valid),
    .mem_enable(mem_enable), .mem_address(mem_address),
    .miss_fixing(miss_fixing), .memory_address(memory_address),
    .memory_data(memory_data), .memory_data_write(memory_data_write),
    .memory_tag_write(memory_tag_write), .stall(stall), .fill_done(fill_done)
  );

  typedef struct { logic [15:0] a; int t; } req_t;
  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          start_cyc;
  req_t        mq[$];
  logic [15:0] req_log[$];
  wr_t         wr_log[$];
  int          wr_count, tag_count, done_count, tag_cyc, done_cyc, first_req_cyc;
  int          mem_lat;
  bit          mem_irr;
  bit          spurious;
  logic [15:0] data_seed;
  int          gap_cnt, gap_idx;
  int          gap_tab[8] = '{0, 2, 1, 3, 0, 1, 2, 3};

  // Fill model: a fill is "busy" until all 8 words have returned, then one done cycle.
  bit          m_busy, m_done;
  logic [15:0] m_base;
  int          m_req, m_ret;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clearLogs();
    req_log.delete();
    wr_log.delete();
    wr_count = 0; tag_count = 0; done_count = 0;
    tag_cyc = -1; done_cyc = -1; first_req_cyc = -1;
    gap_idx = 0;
  endtask

  // In-order memory: returns each request no earlier than mem_lat cycles after it.
  initial begin
    mem_data_valid = 1'b0;
    mem_data_in    = 16'h0;
    gap_cnt        = 0;
    forever begin
      @(posedge clk);
      #2;
      mem_data_valid = 1'b0;
      mem_data_in    = 16'($urandom);
      if (!rst_n) begin
        mq.delete();
        gap_cnt = 0;
      end else if (spurious) begin
        mem_data_valid = 1'b1;
        mem_data_in    = 16'hDEAD;
      end else if (mq.size() > 0 && mq[0].t + mem_lat <= cyc && gap_cnt == 0) begin
        mem_data_valid = 1'b1;
        mem_data_in    = data_seed + 16'(mq[0].a[3:1]);
        void'(mq.pop_front());
        if (mem_irr) begin
          gap_cnt = gap_tab[gap_idx % 8];
          gap_idx++;
        end
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
    end
  end

  always @(negedge clk) begin
    bit          e_en, e_wr, e_tag, e_stall;
    logic [15:0] e_ma, e_ca;
    if (!rst_n) begin
      checkOutput("rst_mem_enable", 16'(mem_enable), 16'h0);
      checkOutput("rst_miss_fixing", 16'(miss_fixing), 16'h0);
      checkOutput("rst_stall", 16'(stall), 16'h0);
      checkOutput("rst_fill_done", 16'(fill_done), 16'h0);
      checkOutput("rst_data_write", 16'(memory_data_write), 16'h0);
      checkOutput("rst_tag_write", 16'(memory_tag_write), 16'h0);
      checkOutput("rst_mem_address", mem_address, 16'h0);
      checkOutput("rst_memory_address", memory_address, 16'h0);
      m_busy = 0; m_done = 0; m_base = 16'h0; m_req = 0; m_ret = 0;
    end else begin
      e_en    = m_busy && m_req < 8;
      e_wr    = m_busy && mem_data_valid;
      e_tag   = e_wr && m_ret == 7;
      e_stall = m_busy || (!m_done && miss_detected);
      e_ma    = m_base + 16'(2 * m_req);
      e_ca    = m_base + 16'(2 * m_ret);
      checkOutput("mem_enable", 16'(mem_enable), 16'(e_en));
      checkOutput("miss_fixing", 16'(miss_fixing), 16'(m_busy));
      checkOutput("stall", 16'(stall), 16'(e_stall));
      checkOutput("fill_done", 16'(fill_done), 16'(m_done));
      checkOutput("data_write", 16'(memory_data_write), 16'(e_wr));
      checkOutput("tag_write", 16'(memory_tag_write), 16'(e_tag));
      checkOutput("memory_data", memory_data, mem_data_in);
      if (e_en) checkOutput("mem_address", mem_address, e_ma);
      if (e_wr) checkOutput("memory_address", memory_address, e_ca);
      if (mem_enable) begin
        mq.push_back('{a: mem_address, t: cyc});
        req_log.push_back(mem_address);
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      if (memory_data_write) begin
        wr_log.push_back('{a: memory_address, d: memory_data});
        wr_count++;
      end
      if (memory_tag_write) begin tag_count++; tag_cyc = cyc; end
      if (fill_done) begin done_count++; done_cyc = cyc; end
      if (m_done) m_done = 0;
      else if (m_busy) begin
        if (e_en) m_req++;
        if (e_wr) m_ret++;
        if (m_ret == 8) begin m_busy = 0; m_done = 1; end
      end else if (miss_detected) begin
        m_busy = 1; m_req = 0; m_ret = 0;
        m_base = miss_address & 16'hFFF0;
      end
    end
  end

  // One full miss; hold=1 keeps miss_detected high (other address) through FILL and DONE.
  task automatic applyStimulus(input logic [15:0] addr, input int lat, input bit irr, input bit hold);
    int n;
    mem_lat = lat;
    mem_irr = irr;
    start_cyc = cyc;
    miss_detected = 1'b1;
    miss_address  = addr;
    @(posedge clk); #1;
    miss_detected = hold;
    miss_address  = hold ? ~addr : addr;
    n = 0;
    while (!fill_done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("fill_done_seen", 16'(fill_done), 16'h1);
    @(posedge clk); #1;
    miss_detected = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h1234;
    spurious = 1'b0;
    mem_lat = 4;
    mem_irr = 1'b0;
    data_seed = 16'hA000;
    clearLogs();

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h1234, 4, 1'b0, 1'b0);
    checkOutput("req_count", 16'(req_log.size()), 16'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("req_addr", req_log[i], 16'h1230 + 16'(2 * i));
      checkOutput("wr_addr", wr_log[i].a, 16'h1230 + 16'(2 * i));
      checkOutput("wr_data", wr_log[i].d, 16'hA000 + 16'(i));
    end
    checkOutput("wr_count_l4", 16'(wr_count), 16'd8);
    checkOutput("tag_count_l4", 16'(tag_count), 16'd1);
    checkOutput("first_req_cycle", 16'(first_req_cyc - start_cyc), 16'd1);
    checkOutput("tag_cycle", 16'(tag_cyc - start_cyc), 16'd12);
    checkOutput("done_cycle", 16'(done_cyc - start_cyc), 16'd13);

    clearLogs();
    data_seed = 16'h5000;
    spurious = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    spurious = 1'b0;
    checkOutput("spurious_writes", 16'(wr_count), 16'd0);
    applyStimulus(16'h2468, 3, 1'b0, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("hold_done_count", 16'(done_count), 16'd1);
    checkOutput("hold_req_count", 16'(req_log.size()), 16'd8);
    checkOutput("hold_first_wr", wr_log[0].a, 16'h2460);
    checkOutput("hold_last_wr", wr_log[7].a, 16'h246E);

    clearLogs();
    data_seed = 16'h3300;
    mem_lat = 2;
    mem_irr = 1'b0;
    miss_detected = 1'b1;
    miss_address = 16'h3000;
    @(posedge clk); #1;
    miss_detected = 1'b0;
    n = 0;
    while (wr_count < 5 && n < 50) begin @(posedge clk); #1; n++; end
    checkOutput("five_returns", 16'(wr_count), 16'd5);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("reset_no_tag", 16'(tag_count), 16'd0);

    clearLogs();
    data_seed = 16'h7700;
    applyStimulus(16'hFFFE, 2, 1'b1, 1'b0);
    checkOutput("irr_req_count", 16'(req_log.size()), 16'd8);
    checkOutput("irr_wr_count", 16'(wr_count), 16'd8);
    checkOutput("irr_tag_count", 16'(tag_count), 16'd1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("irr_wr_addr", wr_log[i].a, 16'hFFF0 + 16'(2 * i));
      checkOutput("irr_wr_data", wr_log[i].d, 16'h7700 + 16'(i));
    end

    clearLogs();
    data_seed = 16'h0100;
    applyStimulus(16'h0040, 4, 1'b0, 1'b0);
    applyStimulus(16'h0080, 1, 1'b0, 1'b0);
    checkOutput("b2b_done_count", 16'(done_count), 16'd2);
    checkOutput("b2b_wr_count", 16'(wr_count), 16'd16);
    checkOutput("b2b_first_a", wr_log[0].a, 16'h0040);
    checkOutput("b2b_end_a", wr_log[7].a, 16'h004E);
    checkOutput("b2b_first_b", wr_log[8].a, 16'h0080);
    checkOutput("b2b_end_b", wr_log[15].a, 16'h008E);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
